hynoc_ingress_arbiter: RTL and testbench



---
 rtl/hynoc_arb_pkg.sv | 16 +
 rtl/hynoc_ingress_arbiter_if.sv | 20 ++
 rtl/hynoc_rr_picker.sv | 13 +
 rtl/hynoc_ingress_arbiter.sv | 61 ++++++
 tb/tb_hynoc_ingress_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hynoc_arb_pkg.sv
// hynoc_arb_pkg: shared constants, FSM encoding and round-robin search for the ingress arbiter
package hynoc_arb_pkg;
    localparam int FLIT_WIDTH_DEF = 33;
    localparam int EOP_BIT = FLIT_WIDTH_DEF - 1;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;
    localparam int MAX_REQ = 16;
    // First set index searching last+1, last+2, ... modulo nb; -1 when nothing is valid.
    function automatic int next_grant(input logic [MAX_REQ-1:0] vld, input logic [3:0] last, input int nb);
        int r;
        r = -1;
        for (int k = MAX_REQ; k >= 1; k--)
            if (k <= nb && vld[(int'(last) + k) % nb]) r = (int'(last) + k) % nb;
        return r;
    endfunction
endpackage

// File: rtl/hynoc_ingress_arbiter_if.sv
// hynoc_ingress_arbiter_if: requester handshakes plus router ingress port of the arbiter
interface hynoc_ingress_arbiter_if import hynoc_arb_pkg::*; #(
    parameter int NB_REQ = 4,
    parameter int FLIT_WIDTH = EOP_BIT + 1,
    parameter int LOG2_NB_REQ = 2
);
    logic [NB_REQ-1:0] req_valid, req_ready;
    logic [NB_REQ*FLIT_WIDTH-1:0] req_data;
    logic port_ingress_write, port_ingress_full, busy;
    logic [FLIT_WIDTH-1:0] port_ingress_data;
    logic [LOG2_NB_REQ-1:0] grant_idx;
    modport master(
        output req_valid, req_data, port_ingress_full,
        input req_ready, port_ingress_write, port_ingress_data, grant_idx, busy
    );
    modport slave(
        input req_valid, req_data, port_ingress_full,
        output req_ready, port_ingress_write, port_ingress_data, grant_idx, busy
    );
endinterface

// File: rtl/hynoc_rr_picker.sv
// hynoc_rr_picker: combinational round-robin pick of the next valid requester after last_ptr
module hynoc_rr_picker import hynoc_arb_pkg::*; #(
    parameter int NB_REQ = 4,
    parameter int LOG2_NB_REQ = 2
) (
    input  logic [NB_REQ-1:0]      valid,
    input  logic [LOG2_NB_REQ-1:0] last_ptr,
    output logic                   found,
    output logic [LOG2_NB_REQ-1:0] idx
);
    assign found = next_grant(MAX_REQ'(valid), 4'(last_ptr), NB_REQ) >= 0;
    assign idx = LOG2_NB_REQ'(next_grant(MAX_REQ'(valid), 4'(last_ptr), NB_REQ));
endmodule

// File: rtl/hynoc_ingress_arbiter.sv
// hynoc_ingress_arbiter: packet-granular round-robin arbiter onto one HyNoC ingress port; define HYNOC_INGRESS_ARB_BACK2BACK_EN for zero-bubble regrant on EOP
module hynoc_ingress_arbiter import hynoc_arb_pkg::*; #(
    parameter int NB_REQ = 4,
    parameter int FLIT_WIDTH = EOP_BIT + 1,
    parameter int LOG2_NB_REQ = 2
) (
    input logic clk,
    input logic arst,
    hynoc_ingress_arbiter_if.slave bus
);
    typedef enum logic {IDLE = ST_IDLE, BUSY = ST_BUSY} state_t;
    state_t state;
    logic [LOG2_NB_REQ-1:0] last_ptr, pick_ptr, pick_idx;
    logic [NB_REQ-1:0] pick_vld;
    logic pick_found, xfer, eop;

    assign bus.busy = state == BUSY;
    assign bus.port_ingress_data = bus.req_data[bus.grant_idx*FLIT_WIDTH +: FLIT_WIDTH];
    assign xfer = bus.busy && bus.req_valid[bus.grant_idx] && !bus.port_ingress_full;
    assign eop = bus.port_ingress_data[FLIT_WIDTH-1];
    assign bus.port_ingress_write = xfer;
    assign bus.req_ready = (bus.busy && !bus.port_ingress_full) ? NB_REQ'(1) << bus.grant_idx : '0;

`ifdef HYNOC_INGRESS_ARB_BACK2BACK_EN
    // While busy, search the other requesters as if last_ptr were already the current owner
    assign pick_vld = bus.busy ? bus.req_valid & ~(NB_REQ'(1) << bus.grant_idx) : bus.req_valid;
    assign pick_ptr = bus.busy ? bus.grant_idx : last_ptr;
`else
    assign pick_vld = bus.req_valid;
    assign pick_ptr = last_ptr;
`endif

    hynoc_rr_picker #(.NB_REQ(NB_REQ), .LOG2_NB_REQ(LOG2_NB_REQ)) picker (
        .valid(pick_vld),
        .last_ptr(pick_ptr),
        .found(pick_found),
        .idx(pick_idx)
    );

    // Arbitrate in IDLE, hold the owner until its EOP flit has been written
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
            bus.grant_idx <= '0;
            last_ptr <= LOG2_NB_REQ'(NB_REQ - 1);
        end else if (state == IDLE) begin
            if (pick_found) begin
                state <= BUSY;
                bus.grant_idx <= pick_idx;
            end
        end else if (xfer && eop) begin
            last_ptr <= bus.grant_idx;
`ifdef HYNOC_INGRESS_ARB_BACK2BACK_EN
            if (pick_found) bus.grant_idx <= pick_idx;
            else state <= IDLE;
`else
            state <= IDLE;
`endif
        end
    end
endmodule

// File: tb/tb_hynoc_ingress_arbiter.sv
// tb_hynoc_ingress_arbiter: scoreboard bench for the ingress arbiter with directed packet scenarios
module tb_hynoc_ingress_arbiter;
    localparam int N = 4;
    localparam int W = 33;
    localparam int L = 2;
    logic clk = 1'b0;
    logic arst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic [W-1:0] src_q [N][$];
    logic [N-1:0] en = '1;
    logic [N-1:0] fire;
    logic [L+W-1:0] exp_q [$];
    logic [L+W-1:0] e;

    hynoc_ingress_arbiter_if #(.NB_REQ(N), .FLIT_WIDTH(W), .LOG2_NB_REQ(L)) bus();

    hynoc_ingress_arbiter #(.NB_REQ(N), .FLIT_WIDTH(W), .LOG2_NB_REQ(L)) dut (
        .clk(clk),
        .arst(arst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] fl(input int r, input int k, input int n, input int tag);
        return {k == n - 1, 8'(tag), 8'(r), 16'(k)};
    endfunction

    task automatic src(input int r, input int n, input int tag);
        for (int k = 0; k < n; k++) src_q[r].push_back(fl(r, k, n, tag));
    endtask

    task automatic sb_push(input int r, input int n, input int tag, input int upto);
        for (int k = 0; k < upto; k++) exp_q.push_back({L'(r), fl(r, k, n, tag)});
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i] = en[i] && src_q[i].size() > 0;
            bus.req_data[i*W +: W] = src_q[i].size() > 0 ? src_q[i][0] : '0;
        end
    endtask

    function automatic int src_left();
        int s = 0;
        for (int i = 0; i < N; i++) s += src_q[i].size();
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        arst = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        en = '1;
        bus.port_ingress_full = 1'b0;
        refresh();
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_write", bus.port_ingress_write, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_grant", bus.grant_idx, 0);
        step();
        arst = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || src_left() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain_left", exp_q.size(), 0);
        step();
        @(negedge clk);
        chk("drain_busy", bus.busy, 0);
        step();
    endtask

    // Requester model: pop a flit after each accepted transfer, then present the next one
    initial forever begin
        @(posedge clk);
        fire = bus.req_valid & bus.req_ready;
        #1;
        for (int i = 0; i < N; i++)
            if (fire[i] && src_q[i].size() > 0) src_q[i].delete(0);
        refresh();
    end

    // Monitor: every ingress write must match the next scoreboard entry
    initial forever begin
        @(negedge clk);
        if (bus.port_ingress_write) begin
            if (exp_q.size() == 0) chk("unexpected_write", bus.port_ingress_write, 0);
            else begin
                e = exp_q.pop_front();
                chk("wr_grant", bus.grant_idx, e[L+W-1:W]);
                chk("wr_data", bus.port_ingress_data, e[W-1:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.port_ingress_full = 1'b0;
        refresh();
        // single requester, 3-flit packet
        reset_dut();
        src(0, 3, 1);
        sb_push(0, 3, 1, 3);
        refresh();
        @(negedge clk);
        chk("t1_idle_busy", bus.busy, 0);
        chk("t1_idle_write", bus.port_ingress_write, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t1_busy", bus.busy, 1);
            chk("t1_write", bus.port_ingress_write, 1);
        end
        @(negedge clk);
        chk("t1_done_busy", bus.busy, 0);
        drain();
        // all four requesters, two 1-flit packets each: round-robin rotation
        reset_dut();
        for (int r = 0; r < N; r++) begin
            src(r, 1, 20);
            src(r, 1, 21);
        end
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < N; r++) sb_push(r, 1, 20 + p, 1);
        refresh();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
`ifdef HYNOC_INGRESS_ARB_BACK2BACK_EN
            chk("t2_write_pattern", bus.port_ingress_write, (k >= 1 && k <= 8) ? 1 : 0);
`else
            chk("t2_write_pattern", bus.port_ingress_write, k % 2);
`endif
        end
        drain();
        // backpressure stall mid-packet on requester 1 with requester 2 waiting
        reset_dut();
        src(1, 4, 30);
        src(2, 1, 31);
        sb_push(1, 4, 30, 4);
        sb_push(2, 1, 31, 1);
        refresh();
        @(negedge clk);
        @(negedge clk);
        chk("t3_first_write", bus.port_ingress_write, 1);
        step();
        bus.port_ingress_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_stall_write", bus.port_ingress_write, 0);
            chk("t3_stall_ready", bus.req_ready, 0);
            chk("t3_stall_grant", bus.grant_idx, 1);
            chk("t3_stall_busy", bus.busy, 1);
        end
        step();
        bus.port_ingress_full = 1'b0;
        drain();
        // reset during flit 2 of a 4-flit packet
        reset_dut();
        src(1, 4, 40);
        sb_push(1, 4, 40, 1);
        refresh();
        @(negedge clk);
        @(negedge clk);
        chk("t4_flit1_write", bus.port_ingress_write, 1);
        step();
        arst = 1'b1;
        src_q[1].delete();
        refresh();
        #1;
        chk("t4_rst_write", bus.port_ingress_write, 0);
        chk("t4_rst_busy", bus.busy, 0);
        @(negedge clk);
        chk("t4_rst_ready", bus.req_ready, 0);
        chk("t4_rst_write2", bus.port_ingress_write, 0);
        step();
        arst = 1'b0;
        src(0, 1, 41);
        src(2, 1, 42);
        sb_push(0, 1, 41, 1);
        sb_push(2, 1, 42, 1);
        refresh();
        drain();
`ifdef HYNOC_INGRESS_ARB_BACK2BACK_EN
        // back-to-back 2-flit packets from requesters 0 and 2
        reset_dut();
        src(0, 2, 50);
        src(2, 2, 51);
        sb_push(0, 2, 50, 2);
        sb_push(2, 2, 51, 2);
        refresh();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_write", bus.port_ingress_write, 1);
            chk("t5_busy", bus.busy, 1);
        end
        drain();
`endif
        // requester 3 bubbles mid-packet while requester 0 waits
        reset_dut();
        src(3, 3, 60);
        sb_push(3, 3, 60, 3);
        sb_push(0, 1, 61, 1);
        refresh();
        @(negedge clk);
        @(negedge clk);
        chk("t6_first_grant", bus.grant_idx, 3);
        step();
        en[3] = 1'b0;
        src(0, 1, 61);
        refresh();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t6_bubble_write", bus.port_ingress_write, 0);
            chk("t6_bubble_grant", bus.grant_idx, 3);
            chk("t6_bubble_busy", bus.busy, 1);
            chk("t6_bubble_ready", bus.req_ready, 4'b1000);
        end
        step();
        en[3] = 1'b1;
        refresh();
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
